regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, default 32: width of each register entry in bits.
REQ-002 Parameter DEPTH, default 32: number of entries; SHALL be a power of two, at least 4.
REQ-003 Parameter NUM_RD, default 2: number of independent read ports, 1..4.
REQ-004 Parameter ZERO_REG, default 1: when 1, entry 0 reads as zero and ignores writes.
REQ-005 Derived constant AW = clog2(DEPTH) SHALL size every address field.
REQ-006 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-007 rst_n_i  input  1  asynchronous reset, active-low.
REQ-008 rd_addr_i  input  NUM_RD*AW  packed read addresses; port k occupies bits [k*AW +: AW].
REQ-009 rd_data_o  output  NUM_RD*DATA_W  packed read data; port k occupies bits [k*DATA_W +: DATA_W].
REQ-010 wr_en_i  input  1  write strobe.
REQ-011 wr_addr_i  input  AW  write address.
REQ-012 wr_data_i  input  DATA_W  write data.
REQ-013 ready_o  output  1  high when the clear sweep is complete and the array is usable.
REQ-014 clr_i  input  1  one-cycle pulse that requests a full re-clear of the array.

Function
REQ-015 Writes SHALL be synchronous: on the rising edge with wr_en_i=1 and ready_o=1, entry[wr_addr_i] takes wr_data_i.
REQ-016 Reads SHALL be combinational from the array with zero-cycle latency.
REQ-017 Read ports SHALL be independent; any ports may address the same entry in the same cycle.
REQ-018 With ZERO_REG=1, reads of address 0 return 0 and writes to address 0 have no effect.
REQ-019 Controller states: CLEAR, RUN.
REQ-020 In CLEAR, a sweep counter writes 0 to one entry per cycle, starting at entry 0 and ending at entry DEPTH-1.
REQ-021 Transition CLEAR->RUN SHALL occur on the edge that clears entry DEPTH-1, so CLEAR lasts exactly DEPTH cycles.
REQ-022 ready_o SHALL be 0 in CLEAR and 1 in RUN.
REQ-023 Transition RUN->CLEAR SHALL occur on the edge where clr_i=1; the sweep counter restarts at 0.
REQ-024 clr_i asserted while already in CLEAR SHALL restart the sweep counter at 0.
REQ-025 In CLEAR, wr_en_i SHALL be ignored, and every read port SHALL return 0 regardless of array contents.
REQ-026 A write and clr_i in the same RUN cycle: the write SHALL be dropped and the clear SHALL take priority.
REQ-027 The sweep counter SHALL be AW+1 bits wide so that it cannot wrap before the terminal compare.

Reset
REQ-028 Asserting rst_n_i SHALL immediately force state to CLEAR, the sweep counter to 0 and ready_o to 0.
REQ-029 Assertion of rst_n_i is asynchronous; deassertion takes effect on the next rising edge, and the sweep begins on that edge.
REQ-030 Array storage SHALL NOT be reset directly; it is zeroed only by the sweep.
REQ-031 rd_data_o SHALL be 0 on every port from reset assertion until ready_o=1.
REQ-032 Reset mid-sweep or mid-RUN SHALL restart the full sweep; no partial state is retained.

Configuration
REQ-033 Macro REGFILE_BYPASS_EN, when defined, enables write-to-read forwarding.
REQ-034 Forwarding condition: wr_en_i=1, ready_o=1, rd_addr matches wr_addr_i, and the address is not entry 0 under ZERO_REG=1.
REQ-035 With the macro defined, a read port meeting REQ-034 SHALL return wr_data_i in the same cycle.
REQ-036 Without the macro, a read port meeting REQ-034 returns the old contents until the write edge.

Structure
REQ-037 Package regfile_pkg SHALL hold the CLEAR/RUN state enum and the default values for DATA_W, DEPTH and NUM_RD.
REQ-038 The sweep counter and state register SHALL live in sub-module regfile_clear_fsm.
REQ-039 regfile_clear_fsm SHALL output clr_we, clr_addr and ready.
REQ-040 regfile_mp SHALL hold the array, the write multiplexing between sweep and user writes, the read ports and the optional bypass.

Verification
REQ-041 Reset deassert with DEPTH=32 -> ready_o rises after exactly 32 edges; all ports read 0 at every address.
REQ-042 Write 0xDEADBEEF to addr 5; read addr 5 on ports 0 and 1 the next cycle -> both return 0xDEADBEEF.
REQ-043 ZERO_REG=1: write 0x1234 to addr 0 -> every port reads 0 at addr 0.
REQ-044 Bypass defined: same-cycle write 0xA5A5A5A5 to addr 7 with read of addr 7 -> port returns 0xA5A5A5A5 that cycle; with the macro undefined -> returns the previous value.
REQ-045 clr_i pulse in RUN with addr 3 = 0x55 -> ready_o low for 32 cycles; addr 3 then reads 0; a write issued in the clr_i cycle is dropped.
REQ-046 rst_n_i asserted 10 cycles into the sweep -> ready_o stays 0; a fresh 32-cycle sweep starts after deassertion.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the multi-port register file.
// Build option: REGFILE_BYPASS_EN enables write-to-read forwarding.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 32;
    localparam int NUM_RD_DEF = 2;

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sweep controller: zeroes one entry per cycle, then reports ready.
// Used by regfile_mp; REGFILE_BYPASS_EN does not affect this block.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clr_i,
    output logic          clr_we_o,
    output logic [AW-1:0] clr_addr_o,
    output logic          ready_o
);

    localparam int         CW   = AW + 1;
    localparam logic [AW:0] LAST = CW'(DEPTH - 1);

    state_e      r_state;
    state_e      w_state_nxt;
    logic [AW:0] r_cnt;
    logic [AW:0] w_cnt_nxt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            CLEAR: begin
                if (clr_i) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == LAST) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RUN: begin
                if (clr_i) begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
        endcase
    end

    assign clr_we_o   = (r_state == CLEAR);
    assign clr_addr_o = r_cnt[AW-1:0];
    assign ready_o    = (r_state == RUN);

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with sweep clear and optional zero entry.
// Build option: REGFILE_BYPASS_EN forwards same-cycle write data to reads.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int NUM_RD   = NUM_RD_DEF,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [NUM_RD*AW-1:0]     rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    input  logic                     wr_en_i,
    input  logic [AW-1:0]            wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    output logic                     ready_o,
    input  logic                     clr_i
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_clr_we;
    logic [AW-1:0]     w_clr_addr;
    logic              w_ready;
    logic              w_wr_zero;
    logic              w_user_we;
    logic              w_we;
    logic [AW-1:0]     w_waddr;
    logic [DATA_W-1:0] w_wdata;

    regfile_clear_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_fsm (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .clr_i      (clr_i),
        .clr_we_o   (w_clr_we),
        .clr_addr_o (w_clr_addr),
        .ready_o    (w_ready)
    );

    // A clear request in the same cycle wins over the user write.
    assign w_wr_zero = (ZERO_REG != 0) && (wr_addr_i == '0);
    assign w_user_we = w_ready & wr_en_i & ~clr_i & ~w_wr_zero;
    assign w_we      = w_clr_we | w_user_we;
    assign w_waddr   = w_clr_we ? w_clr_addr : wr_addr_i;
    assign w_wdata   = w_clr_we ? '0 : wr_data_i;

    always_ff @(posedge clk_i) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic w_fwd_ok;
    assign w_fwd_ok = w_ready & wr_en_i & ~w_wr_zero;
`endif

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0]     w_ra;
        logic              w_ra_zero;
        logic              w_byp;
        logic [DATA_W-1:0] w_rd;

        assign w_ra      = rd_addr_i[k*AW +: AW];
        assign w_ra_zero = (ZERO_REG != 0) && (w_ra == '0);
`ifdef REGFILE_BYPASS_EN
        assign w_byp     = w_fwd_ok && (w_ra == wr_addr_i);
`else
        assign w_byp     = 1'b0;
`endif

        always_comb begin
            w_rd = r_mem[w_ra];
            if (!w_ready || w_ra_zero) begin
                w_rd = '0;
            end else if (w_byp) begin
                w_rd = wr_data_i;
            end
        end

        assign rd_data_o[k*DATA_W +: DATA_W] = w_rd;
    end

    assign ready_o = w_ready;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: vector table, corner sequences, random run.
// Expectations follow REGFILE_BYPASS_EN when the bench is built with it.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic              clr = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [DW-1:0]     wr_data = '0;
    logic [AW-1:0]     ra [NRD];
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic              ready;

    assign rd_addr = {ra[1], ra[0]};

    always #5 clk = ~clk;

    regfile_mp dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .ready_o   (ready),
        .clr_i     (clr)
    );

    // Reference model: contents plus number of clear cycles still owed.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_left;
    int            n_pass = 0;
    int            n_tot  = 0;

    task automatic m_reset();
        m_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    endtask

    task automatic m_edge();
        if (!rst_n) return;
        if (m_left > 0) begin
            m_left = clr ? DEPTH : m_left - 1;
        end else if (clr) begin
            m_reset();
        end else if (wr_en && wr_addr != 0) begin
            m_mem[wr_addr] = wr_data;
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (m_left > 0) return '0;
        if (a == 0) return '0;
        if (BYP && wr_en && a == wr_addr) return wr_data;
        return m_mem[a];
    endfunction

    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic check_ports(input string nm);
        #1;
        chk({nm, "/ready"}, {31'b0, ready}, {31'b0, m_left == 0});
        for (int k = 0; k < NRD; k++)
            chk($sformatf("%s/port%0d@%0d", nm, k, ra[k]),
                rd_data[k*DW +: DW], exp_rd(ra[k]));
    endtask

    task automatic count_sweep(input string nm);
        int n;
        n = 0;
        while (!ready && n < 100) begin
            ra[0] = AW'(n);
            ra[1] = AW'(31 - n);
            check_ports({nm, "/sweep"});
            tick();
            n++;
        end
        chk({nm, "/sweep_len"}, DW'(n), DW'(DEPTH));
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] r0;
        logic [AW-1:0] r1;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
        tbl[1] = '{1'b1, 5'd0,  32'h00001234, 5'd0,  5'd0,  32'h0,        32'h0};
        tbl[2] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd5,  32'hCAFEF00D, 32'hDEADBEEF};
        tbl[3] = '{1'b1, 5'd1,  32'h11111111, 5'd1,  5'd31, 32'h11111111, 32'hCAFEF00D};
        tbl[4] = '{1'b0, 5'd5,  32'h00000000, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
        tbl[5] = '{1'b1, 5'd5,  32'h0BADF00D, 5'd5,  5'd1,  32'h0BADF00D, 32'h11111111};

        ra[0] = '0;
        ra[1] = '0;
        m_reset();

        // Reset state and first sweep
        tick();
        tick();
        check_ports("reset");
        rst_n = 1'b1;
        count_sweep("init");
        for (int a = 0; a < DEPTH; a++) begin
            ra[0] = AW'(a);
            ra[1] = AW'(DEPTH - 1 - a);
            check_ports("zeroed");
        end

        // Vector table: write, then read next cycle
        for (int i = 0; i < 6; i++) begin
            wr_en   = tbl[i].we;
            wr_addr = tbl[i].wa;
            wr_data = tbl[i].wd;
            tick();
            wr_en = 1'b0;
            ra[0] = tbl[i].r0;
            ra[1] = tbl[i].r1;
            #1;
            chk($sformatf("vec%0d/p0", i), rd_data[DW-1:0], tbl[i].e0);
            chk($sformatf("vec%0d/p1", i), rd_data[2*DW-1:DW], tbl[i].e1);
            check_ports($sformatf("vec%0d", i));
        end

        // Same-cycle write and read of addr 7
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h00000011;
        tick();
        wr_data = 32'hA5A5A5A5;
        ra[0] = 5'd7;
        ra[1] = 5'd6;
        #1;
        chk("bypass/same_cycle", rd_data[DW-1:0],
            BYP ? 32'hA5A5A5A5 : 32'h00000011);
        check_ports("bypass");
        tick();
        wr_en = 1'b0;
        #1;
        chk("bypass/after_edge", rd_data[DW-1:0], 32'hA5A5A5A5);

        // Clear pulse with a colliding write
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
        tick();
        wr_en = 1'b0;
        ra[0] = 5'd3;
        ra[1] = 5'd9;
        #1;
        chk("clr/pre", rd_data[DW-1:0], 32'h55);
        clr = 1'b1; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        tick();
        clr = 1'b0; wr_en = 1'b0;
        count_sweep("clr");
        ra[0] = 5'd3;
        ra[1] = 5'd9;
        #1;
        chk("clr/addr3", rd_data[DW-1:0], 32'h0);
        chk("clr/addr9_dropped", rd_data[2*DW-1:DW], 32'h0);

        // Reset asserted 10 cycles into a sweep
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h12121212;
        tick();
        wr_en = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        #2;
        rst_n = 1'b0;
        m_reset();
        check_ports("midreset");
        tick();
        tick();
        check_ports("midreset_hold");
        rst_n = 1'b1;
        count_sweep("resweep");

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = AW'($urandom);
            wr_data = $urandom;
            clr     = ($urandom_range(0, 59) == 0);
            ra[0]   = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
            ra[1]   = AW'($urandom);
            check_ports($sformatf("rand%0d", i));
            tick();
        end
        clr = 1'b0;
        wr_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
